// File: rtl/line_burst_adapter.sv
// Whole-line to multi-beat burst adapter between the L2 side and physical memory.
// Define POSTED_WRITE_EN to acknowledge writes on acceptance and drain the burst afterwards.
module line_burst_adapter #(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_line   = 256,
    parameter int unsigned s_beat   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [31:0]       line_address,
    input  logic [s_line-1:0] line_wdata,
    output logic              line_resp,
    output logic [s_line-1:0] line_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [s_beat-1:0] pmem_wdata,
    input  logic [s_beat-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int unsigned N  = s_line / s_beat;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
    localparam logic [31:0]   ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP
`ifdef POSTED_WRITE_EN
        , DRAIN
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [s_line-1:0] buf_q, buf_d;
    logic [s_line-1:0] rdata_q, rdata_d;
`ifdef POSTED_WRITE_EN
    logic              first_q, first_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
`ifdef POSTED_WRITE_EN
            first_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
`ifdef POSTED_WRITE_EN
            first_q <= first_d;
`endif
        end
    end

    // The beat buffer doubles as write-line capture and read reassembly;
    // line_rdata only updates when a read's final beat lands.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        buf_d      = buf_q;
        rdata_d    = rdata_q;
        line_resp  = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
`ifdef POSTED_WRITE_EN
        first_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (line_write) begin
                    addr_d = line_address & ADDR_MASK;
                    buf_d  = line_wdata;
                    cnt_d  = '0;
`ifdef POSTED_WRITE_EN
                    first_d = 1'b1;
                    state_d = DRAIN;
`else
                    state_d = WRITE;
`endif
                end else if (line_read) begin
                    addr_d  = line_address & ADDR_MASK;
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    buf_d[s_beat*cnt_q +: s_beat] = pmem_rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        rdata_d = buf_d;
                        state_d = RESP;
                    end
                end
            end
            WRITE: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                line_resp = 1'b1;
                state_d   = IDLE;
            end
`ifdef POSTED_WRITE_EN
            DRAIN: begin
                pmem_write = 1'b1;
                line_resp  = first_q;
                if (pmem_resp) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign line_rdata   = rdata_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = buf_q[s_beat*cnt_q +: s_beat];

endmodule

// File: tb/tb_line_burst_adapter.sv
// Randomised self-checking bench for line_burst_adapter against a line-level model.
// Define POSTED_WRITE_EN here as well when the design is built with posted writes.
module tb_line_burst_adapter;

    localparam int N  = 4;
    localparam int SB = 64;
    localparam int SL = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          line_read, line_write;
    logic [31:0]   line_address;
    logic [SL-1:0] line_wdata;
    logic          line_resp;
    logic [SL-1:0] line_rdata;
    logic          pmem_read, pmem_write;
    logic [31:0]   pmem_address;
    logic [SB-1:0] pmem_wdata;
    logic [SB-1:0] pmem_rdata;
    logic          pmem_resp;

    int            checks = 0;
    int            errors = 0;
    logic [SL-1:0] exp_rdata = '0;

    line_burst_adapter #(.s_offset(5), .s_line(SL), .s_beat(SB)) dut (
        .clk(clk), .rst_n(rst_n),
        .line_read(line_read), .line_write(line_write),
        .line_address(line_address), .line_wdata(line_wdata),
        .line_resp(line_resp), .line_rdata(line_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [SL-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        line_read = 1'b0; line_write = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = '0;
    endtask

    // Entered at a negedge; leaves at a negedge with the adapter idle (or chained read pending).
    task automatic run_burst(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [SL-1:0] wl, input logic [SL-1:0] rl,
                             input int gmin, input int gmax,
                             input bit chain, input logic [31:0] chain_addr, input string tag);
        logic [31:0] aexp;
        int lat, beat, gap, tgap, guard;
        bit er;
        aexp = addr & 32'hFFFF_FFE0;
        line_read = rd; line_write = wr; line_address = addr; line_wdata = wl;
        pmem_resp = 1'b0;
        @(posedge clk);
        @(negedge clk);
        line_address = $urandom;
        line_wdata   = rand_line();
        lat = 1; beat = 0; guard = 0;
        gap = $urandom_range(gmax, gmin); tgap = gap;
        while (beat < N && guard < 100) begin
            guard++;
            checks++;
            if ({pmem_read, pmem_write} !== {~wr, wr}) begin
                errors++;
                $display("FAIL %s rd/wr strobes beat %0d: got %b expected %b", tag, beat, {pmem_read, pmem_write}, {~wr, wr});
            end
            checks++;
            if (pmem_address !== aexp) begin
                errors++;
                $display("FAIL %s pmem_address: got %h expected %h", tag, pmem_address, aexp);
            end
            if (wr) begin
                checks++;
                if (pmem_wdata !== wl[SB*beat +: SB]) begin
                    errors++;
                    $display("FAIL %s pmem_wdata beat %0d: got %h expected %h", tag, beat, pmem_wdata, wl[SB*beat +: SB]);
                end
            end
`ifdef POSTED_WRITE_EN
            er = wr && (lat == 1);
            if (wr && lat == 2) begin
                line_write = 1'b0;
                line_read  = chain;
                if (chain) line_address = chain_addr;
            end
`else
            er = 1'b0;
`endif
            checks++;
            if (line_resp !== er) begin
                errors++;
                $display("FAIL %s line_resp during burst cycle %0d: got %b expected %b", tag, lat, line_resp, er);
            end
            if (gap > 0) begin
                pmem_resp = 1'b0;
                gap--;
            end else begin
                pmem_resp  = 1'b1;
                pmem_rdata = rl[SB*beat +: SB];
            end
            @(posedge clk);
            lat++;
            if (pmem_resp) begin
                beat++;
                if (beat < N) begin
                    gap = $urandom_range(gmax, gmin);
                    tgap += gap;
                end
            end
            @(negedge clk);
            pmem_resp  = 1'b0;
            pmem_rdata = {$urandom, $urandom};
        end
        checks++;
        if (beat != N) begin
            errors++;
            $display("FAIL %s burst timeout: got %0d beats expected %0d", tag, beat, N);
            do_reset();
            return;
        end
`ifdef POSTED_WRITE_EN
        if (wr) begin
            checks++;
            if ({line_resp, pmem_read, pmem_write} !== 3'b000) begin
                errors++;
                $display("FAIL %s after drain resp/rd/wr: got %b expected 000", tag, {line_resp, pmem_read, pmem_write});
            end
            checks++;
            if (line_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL %s line_rdata after drain: got %h expected %h", tag, line_rdata, exp_rdata);
            end
            return;
        end
`endif
        checks++;
        if (line_resp !== 1'b1) begin
            errors++;
            $display("FAIL %s line_resp at completion: got %b expected 1", tag, line_resp);
        end
        checks++;
        if (lat != N + 1 + tgap) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", tag, lat, N + 1 + tgap);
        end
        if (!wr) exp_rdata = rl;
        checks++;
        if (line_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL %s line_rdata: got %h expected %h", tag, line_rdata, exp_rdata);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({line_resp, pmem_read, pmem_write} !== 3'b000) begin
            errors++;
            $display("FAIL %s after resp resp/rd/wr: got %b expected 000", tag, {line_resp, pmem_read, pmem_write});
        end
        line_read = 1'b0; line_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        line_read = 1'b0; line_write = 1'b0; line_address = '0; line_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({line_resp, pmem_read, pmem_write} !== 3'b000 || pmem_address !== 32'h0 || line_rdata !== '0) begin
            errors++;
            $display("FAIL reset outputs: got resp/rd/wr %b addr %h rdata %h expected zeros", {line_resp, pmem_read, pmem_write}, pmem_address, line_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        logic [SL-1:0] rl;
        rl = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        run_burst(1'b1, 1'b0, 32'h0000_1234, rand_line(), rl, 0, 0, 1'b0, 32'h0, "read_1234");
    endtask

    task automatic test_write_gap();
        logic [SL-1:0] wl;
        wl = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
              64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
        run_burst(1'b0, 1'b1, 32'h0000_0080, wl, rand_line(), 2, 2, 1'b0, 32'h0, "write_gap");
    endtask

    task automatic test_both();
        run_burst(1'b1, 1'b1, $urandom, rand_line(), rand_line(), 0, 1, 1'b0, 32'h0, "both_high");
    endtask

    task automatic test_spurious();
        for (int i = 0; i < 3; i++) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({line_resp, pmem_read, pmem_write} !== 3'b000 || line_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL spurious_resp: got resp/rd/wr %b rdata %h expected 000 rdata %h", {line_resp, pmem_read, pmem_write}, line_rdata, exp_rdata);
            end
        end
        pmem_resp = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        line_read = 1'b1; line_address = 32'h0000_0340;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
        end
        pmem_resp = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({line_resp, pmem_read, pmem_write} !== 3'b000 || pmem_address !== 32'h0 || line_rdata !== '0) begin
            errors++;
            $display("FAIL reset_mid_read outputs: got resp/rd/wr %b addr %h rdata %h expected zeros", {line_resp, pmem_read, pmem_write}, pmem_address, line_rdata);
        end
        line_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = '0;
        run_burst(1'b1, 1'b0, 32'h0000_0100, rand_line(), rand_line(), 0, 0, 1'b0, 32'h0, "read_after_reset");
    endtask

    task automatic test_random();
        bit wr;
        for (int i = 0; i < 16; i++) begin
            wr = 1'($urandom_range(1, 0));
            run_burst(~wr, wr, $urandom, rand_line(), rand_line(), 0, 3, 1'b0, 32'h0, "random");
        end
    endtask

`ifdef POSTED_WRITE_EN
    task automatic test_posted();
        run_burst(1'b0, 1'b1, 32'h0000_0500, rand_line(), rand_line(), 0, 2, 1'b1, 32'h0000_0640, "posted_write");
        checks++;
        if (pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL posted read accepted during drain: got %b expected 0", pmem_read);
        end
        run_burst(1'b1, 1'b0, 32'h0000_0640, rand_line(), rand_line(), 0, 0, 1'b0, 32'h0, "posted_chained_read");
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write_gap();
        test_spurious();
        test_both();
        test_reset_mid_read();
        test_random();
`ifdef POSTED_WRITE_EN
        test_posted();
`endif
        test_spurious();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
